// File: rtl/dsp_dma_pkg.sv
// Shared types and helpers for the SCU DSP DMA engine.
package dsp_dma_pkg;

  localparam int RAM_BANK_WORDS = 64;
  localparam int DSP_WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXT  = 3'd1,
    ST_RAMW = 3'd2,
    ST_RRD  = 3'd3,
    ST_RCAP = 3'd4,
    ST_FIN  = 3'd5
  } dma_state_e;

  function automatic logic [8:0] step_bytes(input logic [2:0] code);
    logic [8:0] b;
    unique case (code)
      3'd0:    b = 9'd0;
      3'd1:    b = 9'd4;
      3'd2:    b = 9'd8;
      3'd3:    b = 9'd16;
      3'd4:    b = 9'd32;
      3'd5:    b = 9'd64;
      3'd6:    b = 9'd128;
      default: b = 9'd256;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dsp_dma_ctrl.sv
// SCU DSP DMA engine: moves words between external bus and DSP data RAM.
// Define DSP_DMA_TIMEOUT_EN to enable the external ack timeout (ERR).
import dsp_dma_pkg::*;

module dsp_dma_ctrl #(
  parameter int EXT_AW  = 27,
  parameter int CNT_W   = 8,
  parameter int ACK_TMO = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              DIR,
  input  logic [1:0]        BANK,
  input  logic [5:0]        RAM_START,
  input  logic [EXT_AW-1:0] EXT_START,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [2:0]        STEP,
  output logic [EXT_AW-1:0] EXT_A,
  output logic [31:0]       EXT_DO,
  input  logic [31:0]       EXT_DI,
  output logic              EXT_REQ,
  output logic              EXT_WE,
  input  logic              EXT_ACK,
  output logic [7:0]        RAM_ADDR,
  output logic [31:0]       RAM_DATA,
  output logic              RAM_WREN,
  input  logic [31:0]       RAM_Q,
  output logic              BUSY,
  output logic              DONE,
  output logic [EXT_AW-1:0] EXT_END,
  output logic              ERR
);

  localparam int WW = $clog2(RAM_BANK_WORDS);
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

  dma_state_e              state_q, state_d;
  logic                    dir_q, dir_d;
  logic [1:0]              bank_q, bank_d;
  logic [WW-1:0]           word_q, word_d;
  logic [EXT_AW-1:0]       ext_a_q, ext_a_d;
  logic [EXT_AW-1:0]       end_q, end_d;
  logic [CNT_W:0]          cnt_q, cnt_d;
  logic [2:0]              step_q, step_d;
  logic [DSP_WORD_W-1:0]   data_q, data_d;

  logic [EXT_AW-1:0]       ext_nxt;
  logic                    last;
  logic                    tmo_hit;

  assign ext_nxt = ext_a_q + EXT_AW'(step_bytes(step_q));
  assign last    = (cnt_q == CNT_ONE);

`ifdef DSP_DMA_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_d   = (state_q == ST_EXT) ? tmo_q + TW'(1) : '0;
  assign tmo_hit = (state_q == ST_EXT) && !ABORT && !EXT_ACK &&
                   (tmo_q == TW'(ACK_TMO));
  assign ERR     = tmo_hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (ACK_TMO == 0);
  assign tmo_hit    = 1'b0;
  assign ERR        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bank_d  = bank_q;
    word_d  = word_q;
    ext_a_d = ext_a_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          dir_d   = DIR;
          bank_d  = BANK;
          word_d  = RAM_START;
          ext_a_d = EXT_START;
          step_d  = STEP;
          cnt_d   = (COUNT == '0) ? CNT_MAX : {1'b0, COUNT};
          state_d = DIR ? ST_RRD : ST_EXT;
        end
      end
      ST_EXT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (EXT_ACK) begin
          if (!dir_q) begin
            data_d  = EXT_DI;
            state_d = ST_RAMW;
          end else begin
            word_d  = word_q + WW'(1);
            ext_a_d = ext_nxt;
            cnt_d   = cnt_q - CNT_ONE;
            state_d = last ? ST_FIN : ST_RRD;
          end
        end else if (tmo_hit) begin
          // failing word's address is reported instead of an end address
          end_d   = ext_a_q;
          state_d = ST_IDLE;
        end
      end
      ST_RAMW: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else begin
          word_d  = word_q + WW'(1);
          ext_a_d = ext_nxt;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = last ? ST_FIN : ST_EXT;
        end
      end
      ST_RRD: begin
        state_d = ABORT ? ST_IDLE : ST_RCAP;
      end
      ST_RCAP: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = RAM_Q;
          state_d = ST_EXT;
        end
      end
      ST_FIN: begin
        if (!ABORT) end_d = ext_a_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      bank_q  <= '0;
      word_q  <= '0;
      ext_a_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      bank_q  <= bank_d;
      word_q  <= word_d;
      ext_a_q <= ext_a_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      data_q  <= data_d;
    end
  end

  // ABORT gates the strobes combinationally so they drop in the abort cycle
  assign BUSY     = (state_q != ST_IDLE);
  assign EXT_REQ  = (state_q == ST_EXT) && !ABORT;
  assign EXT_WE   = (state_q == ST_EXT) && !ABORT && dir_q;
  assign EXT_A    = ext_a_q;
  assign EXT_DO   = data_q;
  assign RAM_ADDR = {bank_q, word_q};
  assign RAM_DATA = data_q;
  assign RAM_WREN = (state_q == ST_RAMW) && !ABORT;
  assign DONE     = (state_q == ST_FIN) && !ABORT;
  assign EXT_END  = DONE ? ext_a_q : end_q;

endmodule

// File: doc/dsp_dma_ctrl.md
Name: dsp_dma_ctrl

Overview:
- DMA engine for the SCU DSP.
- Moves 32-bit words between the external bus and the DSP data RAM (4 banks x 64 words).
- Sits directly upstream of the DSP data RAM instance: drives its write port and address, and consumes its read data.
- Started by the DSP DMA instruction decode; reports busy/done back to the DSP sequencer.

Parameters:
- EXT_AW, 27, external byte-address width.
- CNT_W, 8, transfer-count width; a loaded count of 0 means 2**CNT_W words.
- ACK_TMO, 255, ack-timeout cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST  in  1  async active-high reset
- START  in  1  one-cycle start strobe; ignored while BUSY=1
- ABORT  in  1  stop the transfer and return to idle
- DIR  in  1  0 = external->RAM, 1 = RAM->external
- BANK  in  2  data RAM bank
- RAM_START  in  6  first word address within BANK
- EXT_START  in  EXT_AW  first external byte address
- COUNT  in  CNT_W  words to move
- STEP  in  3  external increment code
- EXT_A  out  EXT_AW  external byte address
- EXT_DO  out  32  external write data
- EXT_DI  in  32  external read data
- EXT_REQ  out  1  bus request
- EXT_WE  out  1  bus write qualifier
- EXT_ACK  in  1  bus acknowledge
- RAM_ADDR  out  8  {bank, word} to the data RAM
- RAM_DATA  out  32  RAM write data
- RAM_WREN  out  1  RAM write enable
- RAM_Q  in  32  RAM read data; valid one cycle after RAM_ADDR is stable
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse on normal completion
- EXT_END  out  EXT_AW  external address after the last word
- ERR  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, internal counters 0.
- START in IDLE latches DIR, BANK, RAM_START, EXT_START, COUNT and STEP; BUSY goes 1 on the next cycle.
- STEP decode: byte increment = 0, 4, 8, 16, 32, 64, 128, 256 for codes 0..7.
- External address wraps modulo 2**EXT_AW.
- RAM word address wraps 63->0 within the latched bank; the bank never changes during a transfer.
- FSM states: IDLE, EXT, RAMW, RRD, RCAP, FIN.
- DIR=0 path:
  - IDLE->EXT.
  - EXT: EXT_REQ=1, EXT_WE=0, EXT_A=current address. Hold until EXT_ACK; on ACK capture EXT_DI and go to RAMW.
  - RAMW: RAM_WREN=1 for exactly one cycle with RAM_DATA=captured word. Then advance RAM address, advance external address by the step, decrement count. Go to FIN if the count reaches 0, else EXT.
- DIR=1 path:
  - IDLE->RRD: drive RAM_ADDR.
  - RCAP: latch RAM_Q.
  - EXT: EXT_REQ=1, EXT_WE=1, EXT_DO=latched word; wait for ACK.
  - After ACK: advance and decrement as above, then go to RRD or FIN.
- EXT_REQ is held from assertion through the ACK cycle and deasserted the cycle after ACK. EXT_A and EXT_DO are stable while EXT_REQ=1.
- An ACK seen outside the EXT state is ignored.
- FIN: DONE=1 for one cycle, EXT_END=final external address, BUSY=0 from the next cycle, then IDLE.
- Throughput: DIR=0 takes 2 cycles/word plus ack wait; DIR=1 takes 3 cycles/word plus ack wait.
- ABORT in any non-IDLE state: IDLE on the next cycle, EXT_REQ and RAM_WREN drop immediately, no DONE, EXT_END unchanged.
- ABORT takes priority over ACK in the same cycle; that word is not written.
- START and ABORT together in IDLE: START wins, ABORT is ignored.
- COUNT=0 transfers 2**CNT_W words; with the default CNT_W=8 that is 256 words, which wraps the bank 4 times.
- RAM_ADDR holds its last value when not BUSY; RAM_WREN is asserted only in RAMW.

Optional Feature:
- Macro: DSP_DMA_TIMEOUT_EN.
- Defined: a cycle counter runs while in EXT. If ACK_TMO cycles pass with no ACK:
  - ERR pulses for one cycle and EXT_REQ drops;
  - the FSM goes to IDLE with no DONE;
  - EXT_END = address of the failing word.
- Undefined: EXT waits indefinitely; ERR is tied 0 and there is no counter logic.

Decomposition:
- Package dsp_dma_pkg holds:
  - the state enum (IDLE, EXT, RAMW, RRD, RCAP, FIN);
  - the step_bytes(code) decode function;
  - constants RAM_BANK_WORDS=64 and DSP_WORD_W=32.
- No sub-module needed; the FSM and counters stay in one module.

Test Plan:
- DIR=0, BANK=2, RAM_START=5, EXT_START=0x200000, COUNT=3, STEP=1, ACK one cycle after each REQ -> RAM writes at 0x85, 0x86, 0x87 with the three EXT_DI words; DONE once; EXT_END=0x20000C.
- DIR=1, BANK=1, RAM_START=62, COUNT=4, STEP=2 -> reads from 0x7E, 0x7F, 0x40, 0x41 (wrap); EXT_A = base, +8, +16, +24; EXT_WE=1 each time; EXT_DO matches the RAM contents.
- STEP=0, COUNT=2, DIR=0 -> EXT_A stays constant for both requests; EXT_END = EXT_START.
- ABORT on the cycle ACK arrives, word 2 of 4 -> no RAM_WREN for that word; IDLE next cycle; no DONE; BUSY=0.
- START asserted while BUSY -> ignored; latched parameters unchanged.
- With DSP_DMA_TIMEOUT_EN and ACK withheld -> ERR at REQ+255 cycles; EXT_REQ=0 the next cycle; no DONE.
